// File: rtl/product_bcd_converter.sv
// Binary-to-packed-BCD converter for the multiplier product, using double-dabble at one shift per clock.
// out_valid rises WIDTH edges after acceptance; the result is held until out_ready, and no input is taken while busy or done.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       adj;
  logic [SW-1:0]       shifted;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] bcd_r;

  // Each digit is corrected on its own 4-bit lane, so no carry reaches its neighbour.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[WIDTH+4*d +: 4] >= 4'd5)
        adj[WIDTH+4*d +: 4] = scratch[WIDTH+4*d +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      scratch <= '0;
      cnt     <= '0;
      bcd_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            scratch <= {{(4*DIGITS){1'b0}}, product};
            cnt     <= CW'(WIDTH);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd_r <= shifted[SW-1:WIDTH];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign bcd       = bcd_r;

endmodule
